// File: rtl/seq_mult_pkg.sv
// ----------------------------------------------------------------------------
// seq_mult_pkg
//   Shared definitions for the sequential shift-and-add multiplier:
//     - state_t : controller state encoding (IDLE=0, RUN=1, DONE=2, 2 bits)
//     - clog2() : width of the step counter for an n-bit operand
// ----------------------------------------------------------------------------
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/addern.sv
// ----------------------------------------------------------------------------
// addern
//   n-bit ripple-carry adder built from a chain of full-adder cells.
//   Ports:
//     x, y     [n-1:0] in   addends
//     carryin          in   carry into bit 0
//     s        [n-1:0] out  sum
//     carryout         out  carry out of bit n-1
// ----------------------------------------------------------------------------
module addern #(
    parameter int n = 8
) (
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  logic         carryin,
    output logic [n-1:0] s,
    output logic         carryout
);

    logic [n:0] c;

    assign c[0] = carryin;

    for (genvar i = 0; i < n; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign carryout = c[n];

endmodule

// File: rtl/multi_and.sv
// ----------------------------------------------------------------------------
// multi_and
//   Partial-product gate array: every bit of x is ANDed with the single
//   enable bit en.
//   Ports:
//     x  [n-1:0] in   operand word
//     en         in   gating bit
//     y  [n-1:0] out  x & {n{en}}
// ----------------------------------------------------------------------------
module multi_and #(
    parameter int n = 8
) (
    input  logic [n-1:0] x,
    input  logic         en,
    output logic [n-1:0] y
);

    assign y = x & {n{en}};

endmodule

// File: rtl/shift_add_step.sv
// ----------------------------------------------------------------------------
// shift_add_step
//   One combinational shift-and-add iteration:
//     pp      = M & {n{Q[0]}}
//     {c, s}  = A + pp
//     A'      = {c, s[n-1:1]}
//     Q'      = {s[0], Q[n-1:1]}
//   Ports:
//     a_in  [n-1:0] in   accumulator A
//     q_in  [n-1:0] in   multiplier/low-product register Q
//     m_in  [n-1:0] in   multiplicand M
//     a_out [n-1:0] out  next accumulator A'
//     q_out [n-1:0] out  next Q'
// ----------------------------------------------------------------------------
module shift_add_step #(
    parameter int n = 8
) (
    input  logic [n-1:0] a_in,
    input  logic [n-1:0] q_in,
    input  logic [n-1:0] m_in,
    output logic [n-1:0] a_out,
    output logic [n-1:0] q_out
);

    logic [n-1:0] pp;
    logic [n-1:0] sum;
    logic         carry;

    multi_and #(.n(n)) u_pp (
        .x  (m_in),
        .en (q_in[0]),
        .y  (pp)
    );

    addern #(.n(n)) u_add (
        .x        (a_in),
        .y        (pp),
        .carryin  (1'b0),
        .s        (sum),
        .carryout (carry)
    );

    // The carry re-enters at the top of A, so no product bit is ever dropped.
    assign a_out = {carry, sum[n-1:1]};
    assign q_out = {sum[0], q_in[n-1:1]};

endmodule

// File: rtl/seq_multiplier.sv
// ----------------------------------------------------------------------------
// seq_multiplier
//   Unsigned n x n -> 2n sequential shift-and-add multiplier. One partial
//   product is accumulated per clock; a start/ready handshake accepts
//   operands and a one-cycle done pulse marks a new product on p.
//
//   Optional build macro: SEQ_MULT_EARLY_EXIT_EN
//     When defined, a shadow copy R of the multiplier is shifted alongside Q
//     and the run ends as soon as no set multiplier bits remain; the partial
//     product is then realigned to its final position.
//
//   Ports:
//     clk            in   rising-edge clock
//     rst            in   asynchronous active-high reset
//     start          in   request, sampled only while ready=1
//     a     [n-1:0]  in   multiplicand, sampled with start
//     b     [n-1:0]  in   multiplier, sampled with start
//     ready          out  high in IDLE only
//     done           out  one-cycle pulse, p valid from this cycle
//     p     [2n-1:0] out  product register, held until the next done
// ----------------------------------------------------------------------------
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int n = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [n-1:0]   a,
    input  logic [n-1:0]   b,
    output logic           ready,
    output logic           done,
    output logic [2*n-1:0] p
);

    localparam int CW = clog2(n);

    state_t           state_q, state_d;
    logic [n-1:0]     acc_q, acc_d;     // A
    logic [n-1:0]     q_q, q_d;         // Q
    logic [n-1:0]     m_q, m_d;         // M
    logic [CW-1:0]    count_q, count_d;
    logic [2*n-1:0]   p_q, p_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;

    logic [n-1:0]     acc_step;
    logic [n-1:0]     q_step;
    logic             last_step;

`ifdef SEQ_MULT_EARLY_EXIT_EN
    logic [n-1:0]     r_q, r_d;
    logic [CW:0]      shamt;            // n - steps performed
`endif

    shift_add_step #(.n(n)) u_step (
        .a_in  (acc_q),
        .q_in  (q_q),
        .m_in  (m_q),
        .a_out (acc_step),
        .q_out (q_step)
    );

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        q_d       = q_q;
        m_d       = m_q;
        count_d   = count_q;
        p_d       = p_q;
        done_d    = 1'b0;
        last_step = (count_q == CW'(n - 1));
`ifdef SEQ_MULT_EARLY_EXIT_EN
        r_d       = r_q;
        // count_q <= n-1 in RUN, so this never underflows.
        shamt     = (CW + 1)'(n - 1) - {1'b0, count_q};
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = a;
                    q_d     = b;
                    acc_d   = '0;
                    count_d = '0;
`ifdef SEQ_MULT_EARLY_EXIT_EN
                    r_d     = b;
`endif
                    state_d = RUN;
                end
            end

            RUN: begin
                acc_d   = acc_step;
                q_d     = q_step;
                count_d = count_q + CW'(1);
`ifdef SEQ_MULT_EARLY_EXIT_EN
                r_d       = r_q >> 1;
                // Once R is empty the remaining steps would only shift zeros
                // in; the realignment below applies those shifts at once.
                last_step = last_step || ((r_q >> 1) == '0);
                if (last_step) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    p_d     = {acc_step, q_step} >> shamt;
                end
`else
                if (last_step) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    p_d     = {acc_step, q_step};
                end
`endif
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            q_q     <= '0;
            m_q     <= '0;
            count_q <= '0;
            p_q     <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
`ifdef SEQ_MULT_EARLY_EXIT_EN
            r_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            m_q     <= m_d;
            count_q <= count_d;
            p_q     <= p_d;
            ready_q <= ready_d;
            done_q  <= done_d;
`ifdef SEQ_MULT_EARLY_EXIT_EN
            r_q     <= r_d;
`endif
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign p     = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// ----------------------------------------------------------------------------
// tb_seq_multiplier
//   Self-checking bench for seq_multiplier (n=8): a table of directed
//   operand pairs, an asynchronous mid-run reset sequence, and randomized
//   back-to-back products checked against a plain-arithmetic model.
//   Latency is counted in edges including the start edge.
// ----------------------------------------------------------------------------
module tb_seq_multiplier;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           ready;
    logic           done;
    logic [2*N-1:0] p;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.n(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .p     (p)
    );

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] exp_p;
        bit             hold;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Edges from start edge (inclusive) to the edge after which done is seen.
    function automatic int model_latency(input int bv);
`ifdef SEQ_MULT_EARLY_EXIT_EN
        int msb;
        msb = 0;
        for (int i = 0; i < N; i++) begin
            if (((bv >> i) & 1) == 1) msb = i;
        end
        return msb + 2;
`else
        return N + 1;
`endif
    endfunction

    task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv,
                          input logic [2*N-1:0] exp_p, input bit hold,
                          input string tag);
        int  w;
        int  lat;
        bit  seen;
        logic [2*N-1:0] held_p;
        w = 0;
        while (!ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, " ready before start"}, ready, 1);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        a = N'($urandom);
        b = N'($urandom);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (hold) check({tag, " ready low while busy"}, ready, 0);
            seen = done;
        end
        check({tag, " latency"}, lat + 1, model_latency(int'(bv)));
        check({tag, " product"}, p, exp_p);
        held_p = p;
        start  = 1'b0;
        @(negedge clk);
        check({tag, " done single pulse"}, done, 0);
        check({tag, " ready after done"}, ready, 1);
        check({tag, " product held"}, p, held_p);
    endtask

    initial begin
        int dcount;
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        tbl[0] = '{a: 8'd13,  b: 8'd11,  exp_p: 16'd143,   hold: 1'b0};
        tbl[1] = '{a: 8'd255, b: 8'd255, exp_p: 16'd65025, hold: 1'b0};
        tbl[2] = '{a: 8'd0,   b: 8'd200, exp_p: 16'd0,     hold: 1'b0};
        tbl[3] = '{a: 8'd200, b: 8'd0,   exp_p: 16'd0,     hold: 1'b0};
        tbl[4] = '{a: 8'd200, b: 8'd3,   exp_p: 16'd600,   hold: 1'b1};
        tbl[5] = '{a: 8'd170, b: 8'd85,  exp_p: 16'd14450, hold: 1'b0};
        tbl[6] = '{a: 8'd255, b: 8'd1,   exp_p: 16'd255,   hold: 1'b0};
        tbl[7] = '{a: 8'd128, b: 8'd2,   exp_p: 16'd256,   hold: 1'b0};
        tbl[8] = '{a: 8'd255, b: 8'd128, exp_p: 16'd32640, hold: 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #2;
        check("reset ready", ready, 1);
        check("reset done", done, 0);
        check("reset p", p, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].exp_p, tbl[i].hold,
                   $sformatf("tbl%0d", i));
        end

        // Asynchronous reset four RUN cycles into 77*99; p holds 32640 now.
        a     = 8'd77;
        b     = 8'd99;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async rst p", p, 0);
        check("async rst done", done, 0);
        check("async rst ready", ready, 1);
        @(negedge clk);
        rst    = 1'b0;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("no done for aborted op", dcount, 0);
        check("p zero after abort", p, 0);
        run_op(8'd6, 8'd7, 16'd42, 1'b0, "post rst");

        // Randomized back-to-back operations against a plain product model.
        for (int i = 0; i < 20; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            if (i == 0) rb = 8'd0;
            run_op(ra, rb, (2*N)'(int'(ra) * int'(rb)), i[0],
                   $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors,
                 miscompares);
        $finish;
    end

endmodule
